// File: rtl/alu_seq_ctrl_if.sv
// Request/response bundle for alu_seq_ctrl: two operation requesters and one response channel.
// master = requester/consumer side, slave = the sequencer.
interface alu_seq_ctrl_if;
    logic        req0_valid;
    logic        req0_ready;
    logic [3:0]  req0_op;
    logic [31:0] req0_a;
    logic [31:0] req0_b;

    logic        req1_valid;
    logic        req1_ready;
    logic [3:0]  req1_op;
    logic [31:0] req1_a;
    logic [31:0] req1_b;

    logic        rsp_valid;
    logic        rsp_ready;
    logic        rsp_id;
    logic [31:0] rsp_result;
    logic        rsp_cout;
    logic        rsp_err;

    modport master (
        output req0_valid, req0_op, req0_a, req0_b,
        output req1_valid, req1_op, req1_a, req1_b,
        output rsp_ready,
        input  req0_ready, req1_ready,
        input  rsp_valid, rsp_id, rsp_result, rsp_cout, rsp_err
    );

    modport slave (
        input  req0_valid, req0_op, req0_a, req0_b,
        input  req1_valid, req1_op, req1_a, req1_b,
        input  rsp_ready,
        output req0_ready, req1_ready,
        output rsp_valid, rsp_id, rsp_result, rsp_cout, rsp_err
    );
endinterface

// File: rtl/alu_seq_ctrl.sv
// Two-requester sequencer that runs 32-bit operations over a shared 16-bit ALU in two passes
// (low half, then high half with carry chaining for add/subtract).
module alu_seq_ctrl (
    input  logic          clk,
    input  logic          reset_n,
    alu_seq_ctrl_if.slave bus,
    output logic [15:0]   alu_a,
    output logic [15:0]   alu_b,
    output logic          alu_cin,
    output logic [3:0]    alu_op,
    input  logic [15:0]   alu_c,
    input  logic          alu_cout
);

    typedef enum logic [1:0] {StIdle, StLo, StHi, StResp} state_e;

    state_e      state_q, state_d;
    logic        last_q, last_d;      // id of the requester served most recently
    logic        id_q, id_d;
    logic [3:0]  op_q, op_d;
    logic [15:0] a_hi_q, a_hi_d;
    logic [15:0] b_hi_q, b_hi_d;
    logic [31:0] result_q, result_d;
    logic        cout_q, cout_d;
    logic        err_q, err_d;
    logic [15:0] alu_a_q, alu_a_d;
    logic [15:0] alu_b_q, alu_b_d;
    logic        alu_cin_q, alu_cin_d;
    logic [3:0]  alu_op_q, alu_op_d;

    logic        grant;
    logic        take;
    logic        arith;
    logic [3:0]  sel_op;
    logic [31:0] sel_a;
    logic [31:0] sel_b;

    // Both valid: serve the one not served last; otherwise whichever is valid.
    assign grant = bus.req1_valid && (!bus.req0_valid || !last_q);

    assign bus.req0_ready = reset_n && (state_q == StIdle) && bus.req0_valid && !grant;
    assign bus.req1_ready = reset_n && (state_q == StIdle) && grant;
    assign take           = bus.req0_ready || bus.req1_ready;

    assign sel_op = grant ? bus.req1_op : bus.req0_op;
    assign sel_a  = grant ? bus.req1_a  : bus.req0_a;
    assign sel_b  = grant ? bus.req1_b  : bus.req0_b;

    // Only add (0000) and subtract (0001) chain a carry/borrow between halves.
    assign arith = (op_q[3:1] == 3'b000);

    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        id_d      = id_q;
        op_d      = op_q;
        a_hi_d    = a_hi_q;
        b_hi_d    = b_hi_q;
        result_d  = result_q;
        cout_d    = cout_q;
        err_d     = err_q;
        alu_a_d   = 16'h0000;
        alu_b_d   = 16'h0000;
        alu_cin_d = 1'b0;
        alu_op_d  = 4'h0;

        unique case (state_q)
            StIdle: begin
                if (take) begin
                    id_d     = grant;
                    last_d   = grant;
                    op_d     = sel_op;
                    a_hi_d   = sel_a[31:16];
                    b_hi_d   = sel_b[31:16];
                    result_d = 32'h0000_0000;
                    cout_d   = 1'b0;
                    if (sel_op <= 4'd9) begin
                        err_d    = 1'b0;
                        alu_a_d  = sel_a[15:0];
                        alu_b_d  = sel_b[15:0];
                        alu_op_d = sel_op;
                        state_d  = StLo;
                    end else begin
                        err_d   = 1'b1;
                        state_d = StResp;
                    end
                end
            end
            StLo: begin
                result_d[15:0] = alu_c;
                // alu_cin_q doubles as the carry register between the two passes.
                alu_cin_d      = arith ? alu_cout : 1'b0;
                alu_a_d        = a_hi_q;
                alu_b_d        = b_hi_q;
                alu_op_d       = op_q;
                state_d        = StHi;
            end
            StHi: begin
                result_d[31:16] = alu_c;
                cout_d          = arith ? alu_cout : 1'b0;
                state_d         = StResp;
            end
            StResp: begin
                if (bus.rsp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= StIdle;
            last_q    <= 1'b1;
            id_q      <= 1'b0;
            op_q      <= 4'h0;
            a_hi_q    <= 16'h0000;
            b_hi_q    <= 16'h0000;
            result_q  <= 32'h0000_0000;
            cout_q    <= 1'b0;
            err_q     <= 1'b0;
            alu_a_q   <= 16'h0000;
            alu_b_q   <= 16'h0000;
            alu_cin_q <= 1'b0;
            alu_op_q  <= 4'h0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            id_q      <= id_d;
            op_q      <= op_d;
            a_hi_q    <= a_hi_d;
            b_hi_q    <= b_hi_d;
            result_q  <= result_d;
            cout_q    <= cout_d;
            err_q     <= err_d;
            alu_a_q   <= alu_a_d;
            alu_b_q   <= alu_b_d;
            alu_cin_q <= alu_cin_d;
            alu_op_q  <= alu_op_d;
        end
    end

    assign alu_a   = alu_a_q;
    assign alu_b   = alu_b_q;
    assign alu_cin = alu_cin_q;
    assign alu_op  = alu_op_q;

    // Response fields are forced low outside RESP so nothing stale leaks out.
    assign bus.rsp_valid  = (state_q == StResp);
    assign bus.rsp_id     = bus.rsp_valid && id_q;
    assign bus.rsp_result = {32{bus.rsp_valid}} & result_q;
    assign bus.rsp_cout   = bus.rsp_valid && cout_q;
    assign bus.rsp_err    = bus.rsp_valid && err_q;

    rsp_hold_a: assert property (@(posedge clk) disable iff (!reset_n)
        bus.rsp_valid && !bus.rsp_ready |=> bus.rsp_valid && $stable(bus.rsp_result)
                                            && $stable(bus.rsp_id) && $stable(bus.rsp_err));

    alu_quiet_a: assert property (@(posedge clk) disable iff (!reset_n)
        (state_q == StIdle || state_q == StResp) |-> (alu_op == 4'h0 && alu_a == 16'h0000
                                                     && alu_b == 16'h0000 && !alu_cin));

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Directed bench for alu_seq_ctrl with a behavioural 16-bit ALU attached to the ALU port.
module tb_alu_seq_ctrl;

    logic        clk;
    logic        reset_n;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic        alu_cin;
    logic [3:0]  alu_op;
    logic [15:0] alu_c;
    logic        alu_cout;

    int n_cmp = 0;
    int n_err = 0;

    alu_seq_ctrl_if bus ();

    alu_seq_ctrl dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .bus      (bus),
        .alu_a    (alu_a),
        .alu_b    (alu_b),
        .alu_cin  (alu_cin),
        .alu_op   (alu_op),
        .alu_c    (alu_c),
        .alu_cout (alu_cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Logic ops drive cout high so the sequencer's masking of rsp_cout is observable.
    always_comb begin
        alu_c    = alu_a;
        alu_cout = 1'b1;
        case (alu_op)
            4'd0: {alu_cout, alu_c} = {1'b0, alu_a} + {1'b0, alu_b} + {16'd0, alu_cin};
            4'd1: {alu_cout, alu_c} = {1'b0, alu_a} - {1'b0, alu_b} - {16'd0, alu_cin};
            4'd2: alu_c = alu_a & alu_b;
            4'd3: alu_c = alu_a | alu_b;
            4'd4: alu_c = alu_a ^ alu_b;
            default: ;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
        end
    endtask

    // Present one request on a negedge and complete the transfer on the next posedge.
    task automatic issue(input logic id, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b);
        @(negedge clk);
        if (id) begin
            bus.req1_valid = 1'b1; bus.req1_op = op; bus.req1_a = a; bus.req1_b = b;
        end else begin
            bus.req0_valid = 1'b1; bus.req0_op = op; bus.req0_a = a; bus.req0_b = b;
        end
        #1;
        check("issue_ready", id ? bus.req1_ready : bus.req0_ready, 1);
        check("idle_alu_op", alu_op, 0);
        @(posedge clk);
        #1;
        if (id) bus.req1_valid = 1'b0;
        else    bus.req0_valid = 1'b0;
    endtask

    // Called just after the transfer edge; walks LO/HI and checks the response cycle.
    task automatic expect_rsp(input int lat, input logic id, input logic [3:0] op,
                              input logic [31:0] a, input logic [31:0] b, input logic hi_cin,
                              input logic [31:0] res, input logic cout, input logic err);
        for (int c = 1; c < lat; c++) begin
            @(negedge clk);
            check("rsp_early", bus.rsp_valid, 0);
            if (c == 1) begin
                check("lo_a", alu_a, a[15:0]);
                check("lo_b", alu_b, b[15:0]);
                check("lo_cin", alu_cin, 0);
                check("lo_op", alu_op, op);
            end else begin
                check("hi_a", alu_a, a[31:16]);
                check("hi_b", alu_b, b[31:16]);
                check("hi_cin", alu_cin, hi_cin);
                check("hi_op", alu_op, op);
            end
        end
        @(negedge clk);
        check("rsp_valid", bus.rsp_valid, 1);
        check("rsp_id", bus.rsp_id, id);
        check("rsp_result", bus.rsp_result, res);
        check("rsp_cout", bus.rsp_cout, cout);
        check("rsp_err", bus.rsp_err, err);
        check("resp_alu_op", alu_op, 0);
        check("resp_alu_a", alu_a, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int last_i;
        int nrsp;
        logic exp_id;

        reset_n        = 1'b0;
        bus.rsp_ready  = 1'b1;
        bus.req0_valid = 1'b1; bus.req0_op = 4'h0; bus.req0_a = 32'd0; bus.req0_b = 32'd0;
        bus.req1_valid = 1'b1; bus.req1_op = 4'h0; bus.req1_a = 32'd0; bus.req1_b = 32'd0;

        repeat (2) @(negedge clk);
        check("rst_ready0", bus.req0_ready, 0);
        check("rst_ready1", bus.req1_ready, 0);
        check("rst_rsp_valid", bus.rsp_valid, 0);
        check("rst_rsp_err", bus.rsp_err, 0);
        check("rst_alu_op", alu_op, 0);
        check("rst_alu_a", alu_a, 0);
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        reset_n        = 1'b1;

        // Add carry chain, subtract borrow, logic op with cout masked, wrap-around add.
        issue(0, 4'h0, 32'h0000_FFFF, 32'h0000_0001);
        expect_rsp(3, 0, 4'h0, 32'h0000_FFFF, 32'h0000_0001, 1, 32'h0001_0000, 0, 0);
        issue(1, 4'h1, 32'h0001_0000, 32'h0000_0001);
        expect_rsp(3, 1, 4'h1, 32'h0001_0000, 32'h0000_0001, 1, 32'h0000_FFFF, 0, 0);
        issue(1, 4'h1, 32'h0000_0000, 32'h0000_0001);
        expect_rsp(3, 1, 4'h1, 32'h0000_0000, 32'h0000_0001, 1, 32'hFFFF_FFFF, 1, 0);
        issue(0, 4'h2, 32'hF0F0_FFFF, 32'h0FF0_1234);
        expect_rsp(3, 0, 4'h2, 32'hF0F0_FFFF, 32'h0FF0_1234, 0, 32'h00F0_1234, 0, 0);
        issue(0, 4'h0, 32'hFFFF_FFFF, 32'h0000_0001);
        expect_rsp(3, 0, 4'h0, 32'hFFFF_FFFF, 32'h0000_0001, 1, 32'h0000_0000, 1, 0);

        // Illegal opcode answers next cycle without touching the ALU.
        issue(0, 4'hC, 32'h1234_5678, 32'h9ABC_DEF0);
        expect_rsp(1, 0, 4'hC, 32'h1234_5678, 32'h9ABC_DEF0, 0, 32'h0000_0000, 0, 1);

        // Reset during the HI pass of a req1 add.
        issue(1, 4'h0, 32'h0002_FFFF, 32'h0004_0001);
        @(negedge clk);
        @(negedge clk);
        check("pre_rst_hi_a", alu_a, 16'h0002);
        check("pre_rst_hi_cin", alu_cin, 1);
        reset_n        = 1'b0;
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b1;
        #1;
        check("mid_rst_alu_a", alu_a, 0);
        check("mid_rst_alu_b", alu_b, 0);
        check("mid_rst_alu_cin", alu_cin, 0);
        check("mid_rst_rsp_valid", bus.rsp_valid, 0);
        check("mid_rst_ready0", bus.req0_ready, 0);
        check("mid_rst_ready1", bus.req1_ready, 0);
        @(negedge clk);
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        reset_n        = 1'b1;
        repeat (4) begin
            @(negedge clk);
            check("no_rsp_after_rst", bus.rsp_valid, 0);
        end

        // Both requesters held valid: alternating grants starting at req0, one per 4 cycles.
        bus.req0_valid = 1'b1; bus.req0_op = 4'h0; bus.req0_a = 32'd1;  bus.req0_b = 32'd2;
        bus.req1_valid = 1'b1; bus.req1_op = 4'h0; bus.req1_a = 32'd10; bus.req1_b = 32'd20;
        #1;
        check("arb_first_ready0", bus.req0_ready, 1);
        check("arb_first_ready1", bus.req1_ready, 0);
        last_i = 0;
        nrsp   = 0;
        exp_id = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk);
            if (bus.rsp_valid) begin
                check("arb_id", bus.rsp_id, exp_id);
                check("arb_result", bus.rsp_result, exp_id ? 32'd30 : 32'd3);
                check("arb_spacing", i - last_i, (nrsp == 0) ? 3 : 4);
                last_i = i;
                nrsp++;
                exp_id = !exp_id;
            end
        end
        check("arb_count", nrsp, 4);
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;

        // Backpressure: response held while req0 waits, then exactly one response.
        bus.rsp_ready = 1'b0;
        issue(1, 4'h0, 32'd5, 32'd7);
        bus.req0_valid = 1'b1; bus.req0_op = 4'h0; bus.req0_a = 32'd100; bus.req0_b = 32'd1;
        expect_rsp(3, 1, 4'h0, 32'd5, 32'd7, 0, 32'd12, 0, 0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_valid", bus.rsp_valid, 1);
            check("bp_result", bus.rsp_result, 32'd12);
            check("bp_id", bus.rsp_id, 1);
            check("bp_ready0", bus.req0_ready, 0);
            check("bp_ready1", bus.req1_ready, 0);
        end
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        check("bp_single_rsp", bus.rsp_valid, 0);
        check("bp_next_ready0", bus.req0_ready, 1);
        @(posedge clk);
        #1;
        bus.req0_valid = 1'b0;
        expect_rsp(3, 0, 4'h0, 32'd100, 32'd1, 0, 32'd101, 0, 0);

        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
